// File: rtl/svm_sequencer.sv
// Command sequencer feeding a space-vector modulator: queues phase-voltage triplets,
// issues one per PWM period, and guards the modulator with a period watchdog.
module svm_sequencer #(
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WD_MARGIN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [D_WIDTH-1:0] cmd_vA,
  input  logic [D_WIDTH-1:0] cmd_vB,
  input  logic [D_WIDTH-1:0] cmd_vC,
  input  logic [D_WIDTH-1:0] cfg_period,
  input  logic               cfg_wr,
  input  logic               enable,
  input  logic               clear_fault,
  output logic [D_WIDTH-1:0] svm_vA,
  output logic [D_WIDTH-1:0] svm_vB,
  output logic [D_WIDTH-1:0] svm_vC,
  output logic [D_WIDTH-1:0] svm_period,
  output logic               svm_in_valid,
  input  logic               svm_out_valid,
  output logic               busy,
  output logic               underrun,
  output logic               cfg_err,
  output logic               fault,
  output logic [31:0]        period_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = D_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, FAULT} state_t;

  state_t                 state, state_nx;
  logic [3*D_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   empty, full, push, pop, issue_go;
  logic [D_WIDTH-1:0]     shadow;
  logic [WW-1:0]          wd_cnt, wd_next;
  logic                   wd_expire;

  // Two periods plus margin, widened so a full-scale period cannot wrap.
  function automatic logic [WW-1:0] wd_limit(input logic [D_WIDTH-1:0] p);
    return ({2'b00, p} << 1) + WW'(WD_MARGIN);
  endfunction

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign issue_go  = (state_nx == ISSUE);
  assign pop       = issue_go && !empty;

  assign wd_next   = wd_cnt + WW'(1);
  assign wd_expire = (wd_next >= wd_limit(svm_period));

  assign svm_in_valid = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign fault        = (state == FAULT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable && !empty) state_nx = ISSUE;
      ISSUE:   state_nx = RUN;
      RUN: begin
        if (svm_out_valid)  state_nx = enable ? ISSUE : IDLE;
        else if (wd_expire) state_nx = FAULT;
      end
      FAULT:   if (clear_fault) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Queue storage carries no reset; occupancy lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_vA, cmd_vB, cmd_vC};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      svm_vA       <= '0;
      svm_vB       <= '0;
      svm_vC       <= '0;
      svm_period   <= D_WIDTH'(1000);
      shadow       <= D_WIDTH'(1000);
      period_count <= '0;
      underrun     <= 1'b0;
      cfg_err      <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // Head is latched on the ISSUE-entry edge; an empty queue keeps the last triplet.
      if (pop) {svm_vA, svm_vB, svm_vC} <= mem[rd_ptr[AW-1:0]];
      if (issue_go || state == IDLE) svm_period <= shadow;

      if (issue_go)          wd_cnt <= '0;
      else if (state == RUN) wd_cnt <= wd_next;

      if (state == RUN && svm_out_valid) period_count <= period_count + 32'd1;

      if (clear_fault && state != FAULT) begin
        underrun <= 1'b0;
        cfg_err  <= 1'b0;
      end
      if (issue_go && empty) underrun <= 1'b1;
      if (cfg_wr) begin
        if (cfg_period >= D_WIDTH'(2)) shadow  <= cfg_period;
        else                           cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svm_sequencer.sv
// Scoreboard bench for svm_sequencer: directed commands push expected issues into a queue,
// a negedge monitor compares every svm_in_valid pulse against it.
module tb_svm_sequencer;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cfg_wr, enable, clear_fault, svm_out_valid;
  logic        cmd_ready, svm_in_valid, busy, underrun, cfg_err, fault;
  logic [15:0] cmd_vA, cmd_vB, cmd_vC, cfg_period;
  logic [15:0] svm_vA, svm_vB, svm_vC, svm_period;
  logic [31:0] period_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  svm_sequencer #(.D_WIDTH(16), .FIFO_DEPTH(4), .WD_MARGIN(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vA(cmd_vA), .cmd_vB(cmd_vB), .cmd_vC(cmd_vC),
    .cfg_period(cfg_period), .cfg_wr(cfg_wr), .enable(enable), .clear_fault(clear_fault),
    .svm_vA(svm_vA), .svm_vB(svm_vB), .svm_vC(svm_vC), .svm_period(svm_period),
    .svm_in_valid(svm_in_valid), .svm_out_valid(svm_out_valid),
    .busy(busy), .underrun(underrun), .cfg_err(cfg_err), .fault(fault),
    .period_count(period_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [15:0] a, b, c, p);
    exp_q.push_back({a, b, c, p});
  endtask

  task automatic push(input logic [15:0] a, b, c);
    int n = 0;
    cmd_vA = a; cmd_vB = b; cmd_vC = c; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("push_timeout", 64'd0, 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_iv();
    int n = 0;
    while (!svm_in_valid && n < 20) begin step(); n++; end
    if (n >= 20) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_ov();
    svm_out_valid = 1'b1;
    step();
    svm_out_valid = 1'b0;
  endtask

  // Monitor: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && svm_in_valid) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
      else chk("issue_triplet_period", {svm_vA, svm_vB, svm_vC, svm_period}, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cfg_wr = 1'b0; enable = 1'b0; clear_fault = 1'b0;
    svm_out_valid = 1'b0; cmd_vA = '0; cmd_vB = '0; cmd_vC = '0; cfg_period = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_valid", svm_in_valid, 0);
    chk("rst_triplet", {svm_vA, svm_vB, svm_vC}, 0);
    chk("rst_period", svm_period, 1000);
    chk("rst_period_count", period_count, 0);
    chk("rst_flags", {underrun, cfg_err, fault, busy}, 0);

    // Single command: issue one edge after the accept edge.
    enable = 1'b1;
    expect_issue(100, 200, 300, 1000);
    push(100, 200, 300);
    chk("single_not_yet", svm_in_valid, 0);
    step();
    chk("single_in_valid", svm_in_valid, 1);
    enable = 1'b0;
    step();
    pulse_ov();
    chk("single_count", period_count, 1);
    chk("single_idle", busy, 0);

    // FIFO full, stalled fifth push, in-order drain.
    for (int i = 1; i <= 5; i++) expect_issue(16'(i), 16'(i + 10), 16'(i + 20), 1000);
    for (int i = 1; i <= 4; i++) push(16'(i), 16'(i + 10), 16'(i + 20));
    chk("full_ready_low", cmd_ready, 0);
    cmd_vA = 5; cmd_vB = 15; cmd_vC = 25; cmd_valid = 1'b1;
    repeat (3) step();
    chk("full_stall", {cmd_ready, busy}, 0);
    enable = 1'b1;
    push(5, 15, 25);
    pulse_ov();
    for (int i = 2; i <= 5; i++) begin
      wait_iv();
      step();
      if (i == 5) enable = 1'b0;
      pulse_ov();
    end
    chk("full_count", period_count, 6);
    chk("full_underrun_clear", underrun, 0);

    // Underrun: second issue re-drives the same triplet.
    enable = 1'b1;
    expect_issue(7, 8, 9, 1000);
    expect_issue(7, 8, 9, 1000);
    push(7, 8, 9);
    wait_iv();
    step();
    pulse_ov();
    chk("underrun_reissue", {svm_in_valid, underrun}, 2'b11);
    step();
    enable = 1'b0;
    pulse_ov();
    chk("underrun_sticky", {busy, underrun}, 2'b01);
    clear_fault = 1'b1; step(); clear_fault = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // Period config: new period only at the next issue; illegal value rejected.
    expect_issue(1, 2, 3, 1000);
    expect_issue(4, 5, 6, 500);
    push(1, 2, 3);
    push(4, 5, 6);
    enable = 1'b1;
    wait_iv();
    step();
    cfg_period = 500; cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    chk("cfg_mid_run_hold", svm_period, 1000);
    pulse_ov();
    wait_iv();
    step();
    cfg_period = 1; cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    chk("cfg_err_set", cfg_err, 1);
    enable = 1'b0;
    pulse_ov();
    step();
    chk("cfg_illegal_ignored", svm_period, 500);
    clear_fault = 1'b1; step(); clear_fault = 1'b0;
    chk("cfg_err_cleared", cfg_err, 0);
    chk("cfg_count", period_count, 10);

    // Watchdog: 2*10+8 = 28 RUN cycles without end-of-period.
    cfg_period = 10; cfg_wr = 1'b1; step(); cfg_wr = 1'b0;
    step();
    chk("wd_period_loaded", svm_period, 10);
    expect_issue(11, 12, 13, 10);
    push(11, 12, 13);
    enable = 1'b1;
    wait_iv();
    enable = 1'b0;
    step();
    for (int k = 1; k < 28; k++) begin
      if (fault) chk("wd_early_fault", {16'(k), fault}, {16'(k), 1'b0});
      step();
    end
    chk("wd_cycle28_no_fault", fault, 0);
    step();
    chk("wd_fault", {fault, busy}, 2'b11);
    expect_issue(21, 22, 23, 10);
    push(21, 22, 23);
    repeat (3) step();
    chk("wd_fault_holds", {fault, svm_in_valid}, 2'b10);
    clear_fault = 1'b1; step(); clear_fault = 1'b0;
    chk("wd_cleared_idle", {fault, busy}, 0);
    enable = 1'b1;
    wait_iv();
    enable = 1'b0;
    step();

    // Reset mid-RUN with three commands queued.
    push(31, 32, 33);
    push(34, 35, 36);
    push(37, 38, 39);
    chk("rst_pre_run", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrun_rst_idle", {busy, cmd_ready}, 2'b01);
    chk("midrun_rst_count", period_count, 0);
    enable = 1'b1;
    repeat (3) step();
    chk("midrun_rst_fifo_empty", {busy, svm_in_valid}, 0);
    enable = 1'b0;
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
